// File: rtl/vector_register_file_mp.sv
// Multi-ported vector register file with byte-enabled merged writes, v0 mask tap and a sequential clear engine.
// Define VRF_BYPASS_EN to forward same-cycle accepted writes to the read ports.
module vector_register_file_mp #(
   parameter int VLEN     = 128,
   parameter int NUM_REGS = 32,
   parameter int NUM_RD   = 3,
   parameter int NUM_WR   = 2,
   parameter int AW       = $clog2(NUM_REGS),
   parameter int NB       = VLEN/8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_RD*AW-1:0]   rd_addr,
   output logic [NUM_RD*VLEN-1:0] rd_data,
   input  logic [NUM_WR-1:0]      wr_en,
   input  logic [NUM_WR*AW-1:0]   wr_addr,
   input  logic [NUM_WR*VLEN-1:0] wr_data,
   input  logic [NUM_WR*NB-1:0]   wr_be,
   output logic                   wr_ready,
   output logic [VLEN-1:0]        v0_mask,
   input  logic                   clr_req,
   output logic                   clr_busy,
   output logic                   clr_done
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] CLEAR = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]      state;
   logic [AW-1:0]   cnt;
   logic [VLEN-1:0] mem     [NUM_REGS];
   logic [VLEN-1:0] mem_nxt [NUM_REGS];

   assign clr_busy = (state == CLEAR);
   assign clr_done = (state == DONE);
   assign wr_ready = !clr_busy;
   assign v0_mask  = mem[0];

   // Ports are applied in ascending order so the highest port wins overlapping lanes;
   // out-of-range addresses match no register and are dropped.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) mem_nxt[r] = mem[r];
      for (int w = 0; w < NUM_WR; w++)
         for (int r = 0; r < NUM_REGS; r++)
            for (int b = 0; b < NB; b++)
               if (wr_ready && wr_en[w] && wr_addr[w*AW +: AW] == AW'(r) && wr_be[w*NB+b])
                  mem_nxt[r][b*8 +: 8] = wr_data[w*VLEN + b*8 +: 8];
      if (clr_busy)
         for (int r = 0; r < NUM_REGS; r++)
            if (cnt == AW'(r)) mem_nxt[r] = '0;
   end

   always_comb begin
      rd_data = '0;
      for (int p = 0; p < NUM_RD; p++)
         for (int r = 0; r < NUM_REGS; r++)
            if (rd_addr[p*AW +: AW] == AW'(r))
`ifdef VRF_BYPASS_EN
               rd_data[p*VLEN +: VLEN] = clr_busy ? mem[r] : mem_nxt[r];
`else
               rd_data[p*VLEN +: VLEN] = mem[r];
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) mem[r] <= '0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) mem[r] <= mem_nxt[r];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: if (clr_req) begin
               state <= CLEAR;
               cnt   <= '0;
            end
            CLEAR: begin
               if (cnt == AW'(NUM_REGS-1)) state <= DONE;
               else                        cnt   <= cnt + 1'b1;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vector_register_file_mp.sv
// Scoreboard bench for vector_register_file_mp: merged writes, v0 tap, out-of-range handling, clear engine, reset mid-clear.
module tb_vector_register_file_mp;
   localparam int VLEN = 128, NR = 32, NRD = 3, NWR = 2, AW = 5, NB = 16;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NRD*AW-1:0]     rd_addr;
   logic [NRD*VLEN-1:0]   rd_data;
   logic [NWR-1:0]        wr_en;
   logic [NWR*AW-1:0]     wr_addr;
   logic [NWR*VLEN-1:0]   wr_data;
   logic [NWR*NB-1:0]     wr_be;
   logic                  wr_ready, clr_req, clr_busy, clr_done;
   logic [VLEN-1:0]       v0_mask;

   // small instance with a non power-of-two register count for out-of-range addresses
   logic [2:0]  s_rd_addr, s_wr_addr;
   logic [31:0] s_rd_data, s_wr_data, s_v0;
   logic [0:0]  s_wr_en;
   logic [3:0]  s_wr_be;
   logic        s_wr_ready, s_clr_req, s_clr_busy, s_clr_done;

   always #5 clk = ~clk;

   vector_register_file_mp u_dut (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .wr_ready(wr_ready), .v0_mask(v0_mask), .clr_req(clr_req),
      .clr_busy(clr_busy), .clr_done(clr_done));

   vector_register_file_mp #(.VLEN(32), .NUM_REGS(6), .NUM_RD(1), .NUM_WR(1)) u_small (
      .clk(clk), .rst_n(rst_n), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
      .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_be(s_wr_be),
      .wr_ready(s_wr_ready), .v0_mask(s_v0), .clr_req(s_clr_req),
      .clr_busy(s_clr_busy), .clr_done(s_clr_done));

   int total = 0, bad = 0;
   logic [VLEN-1:0] m [NR];
   bit m_busy = 1'b0;
   logic [VLEN-1:0] exp_q [$];
   int              port_q [$];
   string           tag_q [$];

   task automatic chk(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [VLEN-1:0] fill_val(input int r);
      logic [31:0] w;
      w = 32'hC0DE0000 | r;
      return {4{w}};
   endfunction

   task automatic rd(input int p, input int a, input logic [VLEN-1:0] e, input string tag);
      rd_addr[p*AW +: AW] = a[AW-1:0];
      exp_q.push_back(e);
      port_q.push_back(p);
      tag_q.push_back(tag);
   endtask

   task automatic check_reads();
      logic [VLEN-1:0] e;
      int p;
      string t;
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         p = port_q.pop_front();
         t = tag_q.pop_front();
         chk(t, rd_data[p*VLEN +: VLEN], e);
      end
   endtask

   task automatic wr(input int w, input int a, input logic [VLEN-1:0] d, input logic [NB-1:0] be);
      wr_en[w]               = 1'b1;
      wr_addr[w*AW +: AW]    = a[AW-1:0];
      wr_data[w*VLEN +: VLEN] = d;
      wr_be[w*NB +: NB]      = be;
   endtask

   // model follows accepted writes in port order, so higher ports overwrite overlapping lanes
   task automatic tick();
      int a;
      if (!m_busy)
         for (int w = 0; w < NWR; w++)
            if (wr_en[w]) begin
               a = int'(wr_addr[w*AW +: AW]);
               for (int b = 0; b < NB; b++)
                  if (wr_be[w*NB+b]) m[a][b*8 +: 8] = wr_data[w*VLEN + b*8 +: 8];
            end
      @(posedge clk);
      #1;
      wr_en   = '0;
      clr_req = 1'b0;
      s_wr_en = '0;
   endtask

   initial begin
      int n;
      logic [VLEN-1:0] e3;
      rst_n = 1'b0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0; wr_be = '0; clr_req = 1'b0;
      s_rd_addr = '0; s_wr_addr = '0; s_wr_data = '0; s_wr_en = '0; s_wr_be = '0; s_clr_req = 1'b0;
      for (int r = 0; r < NR; r++) m[r] = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // reset state
      rd(0, 0, '0, "rst_rd0"); rd(1, 5, '0, "rst_rd5"); rd(2, 31, '0, "rst_rd31");
      check_reads();
      chk("rst_v0", v0_mask, '0);
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_busy", clr_busy, 0);
      chk("rst_done", clr_done, 0);

      // partial byte-enable overwrite across cycles
      wr(0, 3, {16{8'hAA}}, 16'hFFFF); tick();
      wr(1, 3, {16{8'h55}}, 16'h000F); tick();
      e3 = {{12{8'hAA}}, {4{8'h55}}};
      rd(0, 3, e3, "be_partial"); check_reads();
      wr(0, 3, {16{8'hFF}}, 16'h0000); tick();
      rd(0, 3, e3, "be_zero"); check_reads();

      // same-cycle merge, highest port wins overlapping lanes
      wr(0, 7, {16{8'h11}}, 16'hFFFF);
      wr(1, 7, {16{8'h22}}, 16'h00FF);
`ifdef VRF_BYPASS_EN
      rd(1, 7, {{8{8'h11}}, {8{8'h22}}}, "same_cycle7");
`else
      rd(1, 7, '0, "same_cycle7");
`endif
      check_reads();
      tick();
      rd(1, 7, {{8{8'h11}}, {8{8'h22}}}, "merged7"); check_reads();

      // v0 tap
      wr(0, 0, {16{8'hF0}}, 16'hFFFF); tick();
      chk("v0_mask", v0_mask, {16{8'hF0}});

      // out-of-range writes dropped, reads return 0
      s_wr_en = 1'b1; s_wr_addr = 3'd2; s_wr_data = 32'hDEADBEEF; s_wr_be = 4'hF; tick();
      s_wr_en = 1'b1; s_wr_addr = 3'd6; s_wr_data = 32'h11111111; tick();
      s_wr_en = 1'b1; s_wr_addr = 3'd7; s_wr_data = 32'h22222222; tick();
      for (int a = 0; a < 8; a++) begin
         s_rd_addr = a[2:0];
         #1;
         chk($sformatf("oor_rd%0d", a), VLEN'(s_rd_data), (a == 2) ? VLEN'(32'hDEADBEEF) : '0);
      end
      chk("oor_v0", VLEN'(s_v0), '0);
      chk("small_ready", VLEN'({s_wr_ready, s_clr_busy, s_clr_done}), VLEN'(3'b100));

      // fill, then full clear with a dropped mid-clear write and ignored requests
      for (int r = 0; r < NR; r += 2) begin
         wr(0, r, fill_val(r), 16'hFFFF);
         wr(1, r + 1, fill_val(r + 1), 16'hFFFF);
         tick();
      end
      rd(0, 17, fill_val(17), "fill17"); check_reads();
      chk("v0_fill", v0_mask, fill_val(0));
      clr_req = 1'b1; tick();
      n = 0;
      while (clr_busy === 1'b1 && n < 100) begin
         n++;
         if (n == 5) begin
            chk("ready_busy", wr_ready, 0);
            rd(0, 3, '0, "mid_cleared"); rd(1, 4, fill_val(4), "mid_live"); check_reads();
            wr(0, 2, {16{8'h77}}, 16'hFFFF);
            clr_req = 1'b1;
            m_busy  = 1'b1;
         end
         tick();
      end
      m_busy = 1'b0;
      chk("clr_cycles", n, 32);
      chk("done_pulse", clr_done, 1);
      chk("busy_in_done", clr_busy, 0);
      clr_req = 1'b1; tick();
      chk("done_once", clr_done, 0);
      chk("req_in_done", clr_busy, 0);
      for (int r = 0; r < NR; r++) m[r] = '0;
      for (int r = 0; r < NR; r += 3) begin
         for (int p = 0; p < NRD; p++)
            if (r + p < NR) rd(p, r + p, m[r + p], $sformatf("cleared%0d", r + p));
         check_reads();
      end

      // reset mid-clear
      wr(0, 20, {16{8'h3C}}, 16'hFFFF); tick();
      rd(0, 20, {16{8'h3C}}, "pre_rst20"); check_reads();
      clr_req = 1'b1; tick();
      repeat (10) tick();
      #2 rst_n = 1'b0;
      for (int r = 0; r < NR; r++) m[r] = '0;
      rd(0, 20, '0, "rst_mid20"); check_reads();
      chk("rst_mid_busy", clr_busy, 0);
      chk("rst_mid_done", clr_done, 0);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("no_done_after_rst", clr_done, 0);
      end
      clr_req = 1'b1; tick();
      n = 0;
      while (clr_busy === 1'b1 && n < 100) begin
         n++;
         tick();
      end
      chk("restart_cycles", n, 32);
      chk("restart_done", clr_done, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end
endmodule
